// File: rtl/onehot_arb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module : onehot_arb_mux_pkg
//  Brief  : Shared constants and the one-hot AND-OR mux helper used by the
//           arbitrated multiplexer and the older combinational mux lab.
//  Rev    : 1.0  initial release
// ============================================================================
package onehot_arb_mux_pkg;

    // Arbitration policy selectors
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Widest channel count the helper below can reduce over; callers zero-pad
    // their select and data columns up to this width.
    localparam int OH_MAX_CH  = 64;

    // One output bit of a one-hot mux: AND each channel bit with its select
    // and OR the results. A zero select yields zero.
    function automatic logic onehot_mux(
        input logic [OH_MAX_CH-1:0] sel,
        input logic [OH_MAX_CH-1:0] data
    );
        return |(sel & data);
    endfunction

endpackage : onehot_arb_mux_pkg
`default_nettype wire

// File: rtl/onehot_arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : rr_arbiter
//  Brief  : Combinational arbiter. Round-robin starting at ptr, or fixed
//           priority (channel 0 highest). Uses a double-width rotate, a
//           lowest-set-bit isolate and an unrotate.
//  Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import onehot_arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = MODE_RR,
    parameter int PW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [N_CH-1:0] grant
);

    localparam logic [N_CH-1:0] c_ONE = {{(N_CH-1){1'b0}}, 1'b1};

    logic [PW-1:0]     w_ptr_eff;
    logic [2*N_CH-1:0] w_req_dbl;
    logic [N_CH-1:0]   w_req_rot;
    logic [N_CH-1:0]   w_pick_rot;
    logic [2*N_CH-1:0] w_pick_dbl;

    // Fixed priority is round-robin with the search always starting at 0.
    assign w_ptr_eff  = (MODE == MODE_FIXED) ? '0 : ptr;

    // Rotate requests right so the channel at ptr lands in bit 0.
    assign w_req_dbl  = {req, req};
    assign w_req_rot  = N_CH'(w_req_dbl >> w_ptr_eff);

    // Lowest set bit of the rotated vector is the winner.
    assign w_pick_rot = w_req_rot & (~w_req_rot + c_ONE);

    // Rotate the winner back to absolute channel position.
    assign w_pick_dbl = {w_pick_rot, w_pick_rot} << w_ptr_eff;
    assign grant      = N_CH'(w_pick_dbl >> N_CH);

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/onehot_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module : onehot_arb_mux
//  Brief  : N-channel arbitrated multiplexer with a registered valid/ready
//           output stage. A one-hot grant steers an AND-OR mux; the winning
//           word and its source channel are captured into the output register.
//  Rev    : 1.0  initial release
// ============================================================================
module onehot_arb_mux
    import onehot_arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 2,
    parameter int MODE = MODE_RR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [N_CH-1:0]   out_grant,
    input  logic              out_ready
);

    localparam int PW = $clog2(N_CH);

    logic              w_load;
    logic [N_CH-1:0]   w_grant;
    logic [W-1:0]      w_mux_data;
    logic [PW-1:0]     ptr_q;

    logic              out_valid_q;
    logic [W-1:0]      out_data_q;
    logic [N_CH-1:0]   out_grant_q;

    logic [OH_MAX_CH-1:0] w_sel_ext;
    logic [OH_MAX_CH-1:0] w_col_ext;

    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE),
        .PW   (PW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (w_grant)
    );

    // Pipe register takes a new word whenever it is empty or being drained.
    assign w_load   = !out_valid_q || out_ready;

    // Grant only reaches producers on load cycles, and never while in reset.
    assign in_ready = rst ? '0 : (w_grant & {N_CH{w_load}});

    // AND-OR one-hot mux, one data bit at a time across all channels.
    always_comb begin
        w_mux_data = '0;
        w_sel_ext  = '0;
        w_col_ext  = '0;
        w_sel_ext[N_CH-1:0] = w_grant;
        for (int b = 0; b < W; b++) begin
            w_col_ext = '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                w_col_ext[ch] = in_data[ch*W + b];
            end
            w_mux_data[b] = onehot_mux(w_sel_ext, w_col_ext);
        end
    end

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [PW-1:0] ptr_d;

            // Next pointer is one past the channel that transferred.
            always_comb begin
                ptr_d = ptr_q;
                for (int i = 0; i < N_CH; i++) begin
                    if (in_ready[i]) begin
                        ptr_d = PW'((i + 1) % N_CH);
                    end
                end
            end

            // Round-robin pointer, advanced only on an actual transfer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_fixed
            assign ptr_q = '0;
        end
    endgenerate

    // Output register: capture the winner on load, otherwise hold the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_grant_q <= '0;
        end else if (w_load) begin
            out_valid_q <= |w_grant;
            out_grant_q <= w_grant;
            if (|w_grant) begin
                out_data_q <= w_mux_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_grant = out_grant_q;

endmodule : onehot_arb_mux
`default_nettype wire
